rv_ctl: RTL

- Multicycle control FSM directly upstream of the RV32I datapath (rv_dp); drives every datapath enable and mux select.
- Consumes the datapath's `instr` (IR contents) and `zero` flag.
- Owns the data-memory read/write handshake, which the datapath does not provide.
- Supports the RV32I subset: R-type ALU, I-type ALU except SRAI, LW, SW, all branches, JAL, JALR.

---
 rtl/rv_ctl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rv_ctl.sv
// Multicycle control FSM for the RV32I datapath: turns IR contents into
// datapath enables/selects and runs the data-memory read/write handshake.
module rv_ctl #(
  parameter int MEMWAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        dmem_ready,
  output logic        pcsourse,
  output logic        pcwrite,
  output logic        pccen,
  output logic        irwrite,
  output logic        regwen,
  output logic        mdrwrite,
  output logic [1:0]  wbsel,
  output logic [1:0]  immsel,
  output logic [1:0]  asel,
  output logic [1:0]  bsel,
  output logic [3:0]  alusel,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        retire,
  output logic [1:0]  fault
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXR, S_EXI, S_WBA, S_ADDR, S_MRD,
    S_WBM, S_MWR, S_BR, S_JAL, S_JR, S_ERR
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] WB_MDR = 2'd0, WB_ALUOUT = 2'd1, WB_PC = 2'd2;
  localparam logic [1:0] IMM_J = 2'd0, IMM_B = 2'd1, IMM_S = 2'd2, IMM_I = 2'd3;
  localparam logic [1:0] ASEL_REG = 2'd0, ASEL_PCC = 2'd1;
  localparam logic [1:0] BSEL_IMM = 2'd0, BSEL_REG = 2'd1;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9;
  localparam logic [1:0] F_NONE = 2'd0, F_ILLEGAL = 2'd1, F_TIMEOUT = 2'd2;

  localparam int CNT_W = (MEMWAIT_MAX > 0) ? $clog2(MEMWAIT_MAX + 1) : 1;

  state_e           state_q, state_d, dec_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [1:0]       fault_q, fault_d;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             alt, timeout, br_taken, br_bad;
  logic [3:0]       br_alu;
  logic             unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign alt          = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // cnt_q counts idle cycles already spent; this cycle reaching the limit
  // without ready is the timeout, while ready in that same cycle still wins.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign timeout = (MEMWAIT_MAX > 0) && !dmem_ready &&
                   (cnt_inc == (CNT_W+1)'(MEMWAIT_MAX));

  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt_op);
    case (f3)
      3'b000:  return alt_op ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt_op ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec_next = S_ERR;
    case (opcode)
      OP_R:              dec_next = S_EXR;
      OP_I:              if (!(funct3 == 3'b101 && alt)) dec_next = S_EXI;
      OP_LOAD, OP_STORE: if (funct3 == 3'b010) dec_next = S_ADDR;
      OP_BRANCH:         dec_next = S_BR;
      OP_JAL:            dec_next = S_JAL;
      OP_JALR:           dec_next = S_ADDR;
      default:           ;
    endcase
  end

  // zero means "equal" after SUB and "not less" after SLT/SLTU.
  always_comb begin
    br_alu   = ALU_SUB;
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  begin br_alu = ALU_SLT;  br_taken = !zero; end
      3'b101:  begin br_alu = ALU_SLT;  br_taken = zero;  end
      3'b110:  begin br_alu = ALU_SLTU; br_taken = !zero; end
      3'b111:  begin br_alu = ALU_SLTU; br_taken = zero;  end
      default: br_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    cnt_d   = '0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        state_d = dec_next;
        if (dec_next == S_ERR) fault_d = F_ILLEGAL;
      end
      S_EXR, S_EXI: state_d = S_WBA;
      S_ADDR: begin
        if (opcode == OP_LOAD)       state_d = S_MRD;
        else if (opcode == OP_STORE) state_d = S_MWR;
        else                         state_d = S_JR;
      end
      S_MRD, S_MWR: begin
        if (dmem_ready) begin
          state_d = (state_q == S_MRD) ? S_WBM : S_FETCH;
        end else if (timeout) begin
          state_d = S_ERR;
          fault_d = F_TIMEOUT;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      S_BR: begin
        if (br_bad) begin
          state_d = S_ERR;
          fault_d = F_ILLEGAL;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WBA, S_WBM, S_JAL, S_JR: state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      fault_q <= F_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Gating on rst makes memory requests drop the instant reset is raised.
  always_comb begin
    pcsourse = 1'b0;
    pcwrite  = 1'b0;
    pccen    = 1'b0;
    irwrite  = 1'b0;
    regwen   = 1'b0;
    mdrwrite = 1'b0;
    wbsel    = WB_MDR;
    immsel   = IMM_J;
    asel     = ASEL_REG;
    bsel     = BSEL_IMM;
    alusel   = ALU_ADD;
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          irwrite = 1'b1;
          pccen   = 1'b1;
          pcwrite = 1'b1;
        end
        S_DECODE: begin
          asel   = ASEL_PCC;
          bsel   = BSEL_IMM;
          alusel = ALU_ADD;
          immsel = (opcode == OP_JAL) ? IMM_J : IMM_B;
        end
        S_EXR: begin
          bsel   = BSEL_REG;
          alusel = alu_sel(funct3, alt);
        end
        S_EXI: begin
          immsel = IMM_I;
          alusel = alu_sel(funct3, 1'b0);
        end
        S_ADDR: immsel = (opcode == OP_STORE) ? IMM_S : IMM_I;
        S_MRD: begin
          dmem_re  = 1'b1;
          mdrwrite = 1'b1;
        end
        S_MWR: begin
          dmem_we = 1'b1;
          retire  = dmem_ready;
        end
        S_WBA, S_WBM: begin
          regwen = 1'b1;
          wbsel  = (state_q == S_WBA) ? WB_ALUOUT : WB_MDR;
          retire = 1'b1;
        end
        S_BR: begin
          if (!br_bad) begin
            bsel     = BSEL_REG;
            alusel   = br_alu;
            pcwrite  = br_taken;
            pcsourse = 1'b1;
            retire   = 1'b1;
          end
        end
        S_JAL, S_JR: begin
          regwen   = 1'b1;
          wbsel    = WB_PC;
          pcwrite  = 1'b1;
          pcsourse = 1'b1;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fault = fault_q;

endmodule
